wshb_mire: RTL and testbench

WSHB_MIRE -- requirements
Module: wshb_mire

---
 rtl/video_pkg.sv | 23 ++
 rtl/pixel_counter.sv | 52 +++++
 rtl/wshb_mire.sv | 133 +++++++++++++
 tb/tb_wshb_mire.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the test-pattern generator: default geometry,
// controller state encoding and the two colours of the grid pattern.
package video_pkg;

  localparam int unsigned HDISP_DEF = 800;
  localparam int unsigned VDISP_DEF = 480;
  localparam int unsigned BURST_DEF = 64;

  localparam logic [31:0] COLOR_WHITE = 32'h00FF_FFFF;
  localparam logic [31:0] COLOR_BLACK = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    PAUSE
  } mire_state_t;

  // White grid line every 16 pixels in both directions, black elsewhere.
  function automatic logic [31:0] mire_color(input logic [3:0] x_lo, input logic [3:0] y_lo);
    return ((x_lo == 4'd0) || (y_lo == 4'd0)) ? COLOR_WHITE : COLOR_BLACK;
  endfunction

endpackage

// File: rtl/pixel_counter.sv
// Raster x/y counter: advances one pixel per strobe, wraps at the end of
// each line and frame, and flags the last pixel of the frame.
module pixel_counter
  import video_pkg::*;
#(
  parameter int unsigned HDISP = HDISP_DEF,
  parameter int unsigned VDISP = VDISP_DEF,
  parameter int unsigned XW    = (HDISP > 1) ? $clog2(HDISP) : 1,
  parameter int unsigned YW    = (VDISP > 1) ? $clog2(VDISP) : 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          advance,
  output logic [XW-1:0] next_x,
  output logic [YW-1:0] next_y,
  output logic          last
);

  localparam logic [XW-1:0] X_MAX = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(VDISP - 1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  assign last = (x == X_MAX) && (y == Y_MAX);

  // Coordinates the counter will hold after this cycle.
  always_comb begin
    next_x = x;
    next_y = y;
    if (advance) begin
      if (x == X_MAX) begin
        next_x = '0;
        next_y = (y == Y_MAX) ? '0 : y + 1'b1;
      end else begin
        next_x = x + 1'b1;
      end
    end
  end

  // Coordinate registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= next_x;
      y <= next_y;
    end
  end

endmodule

// File: rtl/wshb_mire.sv
// Wishbone master that paints a white 16-pixel grid on black into a
// frame buffer, in bursts separated by a one-cycle bus release.
module wshb_mire
  import video_pkg::*;
#(
  parameter int unsigned HDISP = HDISP_DEF,
  parameter int unsigned VDISP = VDISP_DEF,
  parameter int unsigned BURST = BURST_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        enable,
  output logic [31:0] adr,
  output logic [31:0] dat_ms,
  output logic        cyc,
  output logic        stb,
  output logic        we,
  output logic [3:0]  sel,
  output logic [2:0]  cti,
  output logic [1:0]  bte,
  input  logic        ack,
  input  logic        err,
  input  logic        rty,
  output logic        frame_done
);

  localparam int unsigned XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int unsigned YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int unsigned BW = (BURST > 1) ? $clog2(BURST) : 1;

  mire_state_t   state;
  logic [BW-1:0] burst;
  logic          halt;
  logic          xfer_done;
  logic          burst_full;
  logic          last;
  logic [XW-1:0] next_x;
  logic [YW-1:0] next_y;
  logic [31:0]   nx_w;
  logic [31:0]   ny_w;

  assign sel = 4'hF;
  assign cti = '0;
  assign bte = '0;

  // ack wins over err and both advance; rty alone only holds the pixel.
  assign xfer_done  = (state == WRITE) && (ack || err);
  assign burst_full = (burst == BW'(BURST - 1));
  assign nx_w       = 32'(next_x);
  assign ny_w       = 32'(next_y);

  pixel_counter #(
    .HDISP (HDISP),
    .VDISP (VDISP),
    .XW    (XW),
    .YW    (YW)
  ) u_pixel_counter (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .advance (xfer_done),
    .next_x  (next_x),
    .next_y  (next_y),
    .last    (last)
  );

  // Bus controller: registered strobes, address, data and frame pulse.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      burst      <= '0;
      halt       <= 1'b0;
      cyc        <= 1'b0;
      stb        <= 1'b0;
      we         <= 1'b0;
      frame_done <= 1'b0;
      adr        <= '0;
      dat_ms     <= COLOR_WHITE;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            state <= WRITE;
            cyc   <= 1'b1;
            stb   <= 1'b1;
            we    <= 1'b1;
            halt  <= 1'b0;
          end
        end
        WRITE: begin
          if (xfer_done) begin
            adr        <= (ny_w * HDISP + nx_w) << 2;
            dat_ms     <= mire_color(nx_w[3:0], ny_w[3:0]);
            frame_done <= last;
            // The count is cleared when the burst fills, whichever state
            // follows, so a halt at a burst boundary resumes with a fresh burst.
            burst      <= burst_full ? '0 : burst + 1'b1;
            if (!enable || halt) begin
              state <= IDLE;
              cyc   <= 1'b0;
              stb   <= 1'b0;
              we    <= 1'b0;
              halt  <= 1'b0;
            end else if (burst_full) begin
              state <= PAUSE;
              cyc   <= 1'b0;
              stb   <= 1'b0;
              we    <= 1'b0;
            end
          end else begin
            // A retried or still-waiting pixel stays on the bus unchanged;
            // a halt request seen meanwhile is remembered until completion.
            if (rty) stb <= 1'b1;
            if (!enable) halt <= 1'b1;
          end
        end
        PAUSE: begin
          burst <= '0;
          if (enable) begin
            state <= WRITE;
            cyc   <= 1'b1;
            stb   <= 1'b1;
            we    <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wshb_mire.sv
// Bench for wshb_mire with a 32x4 frame and bursts of 8.
module tb_wshb_mire;

  localparam int HD    = 32;
  localparam int VD    = 4;
  localparam int BU    = 8;
  localparam int NPIX  = HD * VD;
  localparam logic [31:0] WHITE = 32'h00FF_FFFF;

  localparam int S_IDLE  = 0;
  localparam int S_WRITE = 1;
  localparam int S_PAUSE = 2;

  logic        sys_clk;
  logic        sys_rst;
  logic        enable;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack, err, rty;
  logic        frame_done;

  wshb_mire #(
    .HDISP (HD),
    .VDISP (VD),
    .BURST (BU)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .enable     (enable),
    .adr        (adr),
    .dat_ms     (dat_ms),
    .cyc        (cyc),
    .stb        (stb),
    .we         (we),
    .sel        (sel),
    .cti        (cti),
    .bte        (bte),
    .ack        (ack),
    .err        (err),
    .rty        (rty),
    .frame_done (frame_done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } pix_t;

  typedef struct {
    logic        rst;
    logic        en;
    logic        a;
    logic        e;
    logic        r;
    logic        cyc;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        fd;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state and scoreboard of the next pixel expected on the bus.
  pix_t exp_q[$];
  int   m_state = S_IDLE;
  int   m_idx   = 0;
  int   m_bc    = 0;
  bit   m_halt  = 1'b0;
  logic m_fd    = 1'b0;

  function automatic pix_t exp_pix(input int idx);
    pix_t p;
    int x, y;
    x = idx % HD;
    y = idx / HD;
    p.adr = 32'(idx * 4);
    p.dat = ((x % 16 == 0) || (y % 16 == 0)) ? WHITE : 32'h0;
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock with the given inputs, model update, then compare DUT to model.
  task automatic step(input logic r, input logic e, input logic a, input logic er, input logic rt);
    bit full;
    sys_rst = r; enable = e; ack = a; err = er; rty = rt;
    @(posedge sys_clk); #1;
    m_fd = 1'b0;
    if (r) begin
      m_state = S_IDLE; m_idx = 0; m_bc = 0; m_halt = 1'b0;
      exp_q.delete();
      exp_q.push_back(exp_pix(0));
    end else begin
      case (m_state)
        S_IDLE: if (e) m_state = S_WRITE;
        S_WRITE: begin
          if (a || er) begin
            m_fd  = (m_idx == NPIX - 1);
            m_idx = (m_idx + 1) % NPIX;
            void'(exp_q.pop_front());
            exp_q.push_back(exp_pix(m_idx));
            m_bc++;
            full = (m_bc == BU);
            if (full) m_bc = 0;
            if (!e || m_halt) begin
              m_state = S_IDLE;
              m_halt  = 1'b0;
            end else if (full) begin
              m_state = S_PAUSE;
            end
          end else if (!e) begin
            m_halt = 1'b1;
          end
        end
        default: m_state = e ? S_WRITE : S_IDLE;
      endcase
    end
    chk("cyc", 32'(cyc), 32'(m_state == S_WRITE));
    chk("stb", 32'(stb), 32'(m_state == S_WRITE));
    chk("we", 32'(we), 32'(m_state == S_WRITE));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    if (m_state == S_WRITE) begin
      chk("adr", adr, exp_q[0].adr);
      chk("dat_ms", dat_ms, exp_q[0].dat);
    end
  endtask

  vec_t tbl[15];

  initial begin
    int hold, fd_pulses, rty_n, guard;
    logic [31:0] save_adr;

    sys_rst = 1'b1; enable = 1'b0; ack = 1'b0; err = 1'b0; rty = 1'b0;

    //             rst   en    ack   err   rty   cyc   adr           dat    fd
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, WHITE, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, WHITE, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, WHITE, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, WHITE, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0004, WHITE, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0008, WHITE, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0008, WHITE, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_000C, WHITE, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0010, WHITE, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0014, WHITE, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0018, WHITE, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_001C, WHITE, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0020, WHITE, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0020, WHITE, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0024, WHITE, 1'b0};

    for (int i = 0; i < 15; i++) begin
      sys_rst = tbl[i].rst; enable = tbl[i].en;
      ack = tbl[i].a; err = tbl[i].e; rty = tbl[i].r;
      @(posedge sys_clk); #1;
      chk($sformatf("tbl%0d.cyc", i), 32'(cyc), 32'(tbl[i].cyc));
      chk($sformatf("tbl%0d.stb", i), 32'(stb), 32'(tbl[i].cyc));
      chk($sformatf("tbl%0d.adr", i), adr, tbl[i].adr);
      chk($sformatf("tbl%0d.dat", i), dat_ms, tbl[i].dat);
      chk($sformatf("tbl%0d.fd", i), 32'(frame_done), 32'(tbl[i].fd));
      if (i == 0) begin
        chk("sel", 32'(sel), 32'hF);
        chk("cti", 32'(cti), 32'h0);
        chk("bte", 32'(bte), 32'h0);
      end
    end

    // Full frame with zero-wait acks, two retries on pixel 5.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    hold = 0; fd_pulses = 0; rty_n = 0;
    for (int c = 0; c < 160; c++) begin
      if (m_state == S_WRITE && exp_q[0].adr == 32'h14 && rty_n < 2) begin
        rty_n++;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      end else begin
        step(1'b0, 1'b1, 1'(m_state == S_WRITE), 1'b0, 1'b0);
      end
      if (cyc && adr == 32'h14 && fd_pulses == 0) hold++;
      if (frame_done) fd_pulses++;
    end
    chk("rty_hold_cycles", 32'(hold), 32'd3);
    chk("frame_done_count", 32'(fd_pulses), 32'd1);

    // Drop enable while a transfer waits three cycles for ack.
    guard = 0;
    while (m_state != S_WRITE && guard < 4) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    chk("reach_write_a", 32'(m_state), 32'(S_WRITE));
    save_adr = exp_q[0].adr;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("halt_cyc", 32'(cyc), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("resume_adr", adr, (save_adr + 32'd4) % 32'(NPIX * 4));

    // Run up to the last pixel and answer it with ack and err together.
    guard = 0;
    while (!(m_state == S_WRITE && m_idx == NPIX - 1) && guard < 400) begin
      step(1'b0, 1'b1, 1'(m_state == S_WRITE), 1'b0, 1'b0);
      guard++;
    end
    chk("reach_last_pixel", 32'(m_idx), 32'(NPIX - 1));
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("last_fd", 32'(frame_done), 32'd1);
    chk("last_next_adr", adr, 32'h0);
    step(1'b0, 1'b1, 1'(m_state == S_WRITE), 1'b0, 1'b0);
    chk("fd_one_cycle", 32'(frame_done), 32'd0);

    // Reset while a transfer is pending.
    guard = 0;
    while (m_state != S_WRITE && guard < 4) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    guard = 0;
    while (m_state != S_WRITE && guard < 4) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    chk("reach_write_b", 32'(m_state), 32'(S_WRITE));
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_cyc", 32'(cyc), 32'd0);
    chk("rst_stb", 32'(stb), 32'd0);
    chk("rst_adr", adr, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("post_rst_adr", adr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
